fetch_line_ctrl: RTL and testbench

- Front-end fetch sequencer that sits between the PC/redirect source, the instruction-memory arbiter and the instruction buffer.
- Holds the fetch PC and issues one 64-byte line request at a time to the arbiter.
- Forwards each returned 512-bit line to the ibuffer with its base PC and first-valid slot.
- Throttles requests with a credit count of free ibuffer entries, and on redirect clears the ibuffer and drops any stale in-flight line.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_line_ctrl_if.sv | 21 ++
 rtl/fetch_credit_ctr.sv | 34 +++
 rtl/fetch_line_ctrl.sv | 126 ++++++++++++
 tb/tb_fetch_line_ctrl.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared constants, state type and helpers for the fetch line sequencer.
package fetch_pkg;
  localparam int LINE_BYTES = 64;
  localparam int LINE_INSTS = 16;
  localparam int INST_W     = 32;
  localparam int OFF_W      = $clog2(LINE_BYTES);
  localparam int IDX_W      = $clog2(LINE_INSTS);
  localparam int CRED_W     = 5;
  localparam logic [63:0] RESET_PC_DEF = 64'h8000_0000;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} fetch_state_t;

  // Number of ibuffer entries a delivered line occupies.
  function automatic logic [CRED_W-1:0] slots_used(input logic [IDX_W-1:0] start_idx);
    return CRED_W'(LINE_INSTS) - CRED_W'(start_idx);
  endfunction
endpackage

// File: rtl/fetch_line_ctrl_if.sv
// Fetch-to-arbiter line request/response channel.
interface fetch_line_ctrl_if #(
  parameter int ADDR_W = 64,
  parameter int LINE_W = 512
);
  logic              ifu2arb_req;
  logic [ADDR_W-1:0] ifu2arb_addr;
  logic              arb2ifu_gnt;
  logic              arb2ifu_rvalid;
  logic [LINE_W-1:0] arb2ifu_rdata;

  modport master (
    output ifu2arb_req, ifu2arb_addr,
    input  arb2ifu_gnt, arb2ifu_rvalid, arb2ifu_rdata
  );

  modport slave (
    input  ifu2arb_req, ifu2arb_addr,
    output arb2ifu_gnt, arb2ifu_rvalid, arb2ifu_rdata
  );
endinterface

// File: rtl/fetch_credit_ctr.sv
// Free-entry credit counter for the instruction buffer; reload restores full depth.
module fetch_credit_ctr
  import fetch_pkg::*;
#(
  parameter int IB_DEPTH = 24
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CRED_W-1:0] consume,
  input  logic              pop,
  input  logic              reload,
  output logic [CRED_W-1:0] credits,
  output logic              can_fetch
);
  localparam logic [CRED_W:0] DEPTH_W = (CRED_W+1)'(IB_DEPTH);

  logic [CRED_W:0] avail;
  logic [CRED_W:0] net;

  assign avail = {1'b0, credits} + {{CRED_W{1'b0}}, pop};
  assign net   = avail - {1'b0, consume};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              credits <= DEPTH_W[CRED_W-1:0];
    else if (reload)         credits <= DEPTH_W[CRED_W-1:0];
    else if (net > DEPTH_W)  credits <= DEPTH_W[CRED_W-1:0];
    else                     credits <= net[CRED_W-1:0];
  end

  assign can_fetch = credits >= CRED_W'(LINE_INSTS);

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    reload || (avail >= {1'b0, consume}));
endmodule

// File: rtl/fetch_line_ctrl.sv
// Fetch line sequencer: one outstanding 64-byte line request at a time, returned
// lines forwarded to the ibuffer, throttled by ibuffer credits, flushed on redirect.
module fetch_line_ctrl
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter int                LINE_W   = LINE_INSTS * INST_W,
  parameter int                IB_DEPTH = 24,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              fetch_hold,
  input  logic              ib_pop,
  fetch_line_ctrl_if.master arb,
  output logic              ib_line_valid,
  output logic [LINE_W-1:0] ib_line_data,
  output logic [ADDR_W-1:0] ib_line_pc,
  output logic [IDX_W-1:0]  ib_line_start_idx,
  output logic              ib_clear,
  output logic              busy
);
  // state | meaning
  // IDLE  | nothing outstanding; request once credits allow and no hold
  // REQ   | request driven with stable address, waiting for grant
  // WAIT  | granted, waiting for the line to return
  // DROP  | granted line went stale on redirect; swallow its response

  localparam logic [ADDR_W-1:0] LINE_MASK  = ~ADDR_W'(LINE_BYTES - 1);
  localparam logic [ADDR_W-1:0] INST_MASK  = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] RESET_ADDR = RESET_PC & LINE_MASK;

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, line_pc;
  logic              first_q, first_d;
  logic [IDX_W-1:0]  start_idx;
  logic [CRED_W-1:0] consume, credits;
  logic              can_fetch, deliver;

  assign line_pc   = pc_q & LINE_MASK;
  assign start_idx = first_q ? pc_q[OFF_W-1:2] : '0;
  assign deliver   = (state_q == WAIT) && arb.arb2ifu_rvalid && !redirect_valid;

  fetch_credit_ctr #(.IB_DEPTH(IB_DEPTH)) u_credit (
    .clk       (clk),
    .rst_n     (rst_n),
    .consume   (consume),
    .pop       (ib_pop),
    .reload    (redirect_valid),
    .credits   (credits),
    .can_fetch (can_fetch)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      // A granted request still owes one response, so it must be drained in DROP.
      case (state_q)
        IDLE:       state_d = IDLE;
        REQ:        state_d = arb.arb2ifu_gnt ? DROP : IDLE;
        WAIT, DROP: state_d = arb.arb2ifu_rvalid ? IDLE : DROP;
        default:    state_d = IDLE;
      endcase
    end else begin
      case (state_q)
        IDLE:    if (can_fetch && !fetch_hold) state_d = REQ;
        REQ:     if (arb.arb2ifu_gnt)          state_d = WAIT;
        WAIT:    if (arb.arb2ifu_rvalid)       state_d = IDLE;
        DROP:    if (arb.arb2ifu_rvalid)       state_d = IDLE;
        default:                               state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    pc_d    = pc_q;
    first_d = first_q;
    consume = '0;
    if (redirect_valid) begin
      pc_d    = redirect_target & INST_MASK;
      first_d = 1'b1;
    end else if (deliver) begin
      pc_d    = line_pc + ADDR_W'(LINE_BYTES);
      first_d = 1'b0;
      consume = slots_used(start_idx);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q              <= RESET_PC;
      first_q           <= 1'b1;
      arb.ifu2arb_req   <= 1'b0;
      arb.ifu2arb_addr  <= RESET_ADDR;
      ib_line_valid     <= 1'b0;
      ib_line_data      <= '0;
      ib_line_pc        <= '0;
      ib_line_start_idx <= '0;
      ib_clear          <= 1'b0;
      busy              <= 1'b0;
    end else begin
      pc_q             <= pc_d;
      first_q          <= first_d;
      arb.ifu2arb_req  <= (state_d == REQ);
      arb.ifu2arb_addr <= pc_d & LINE_MASK;
      ib_line_valid    <= deliver;
      ib_clear         <= redirect_valid;
      busy             <= (state_d != IDLE);
      if (deliver) begin
        ib_line_data      <= arb.arb2ifu_rdata;
        ib_line_pc        <= line_pc;
        ib_line_start_idx <= start_idx;
      end
    end
  end

  a_credit_cap: assert property (@(posedge clk) disable iff (!rst_n)
    credits <= CRED_W'(IB_DEPTH));
endmodule

// File: tb/tb_fetch_line_ctrl.sv
// Randomized bench for fetch_line_ctrl against a transaction-level model of the
// fetch PC, ibuffer occupancy and the single outstanding line request.
module tb_fetch_line_ctrl;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         redirect_valid;
  logic [63:0]  redirect_target;
  logic         fetch_hold;
  logic         ib_pop;
  logic         ib_line_valid;
  logic [511:0] ib_line_data;
  logic [63:0]  ib_line_pc;
  logic [3:0]   ib_line_start_idx;
  logic         ib_clear;
  logic         busy;

  fetch_line_ctrl_if #(.ADDR_W(64), .LINE_W(512)) arb_if ();

  fetch_line_ctrl #(
    .ADDR_W(64), .LINE_W(512), .IB_DEPTH(24), .RESET_PC(64'h8000_0000)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .redirect_valid    (redirect_valid),
    .redirect_target   (redirect_target),
    .fetch_hold        (fetch_hold),
    .ib_pop            (ib_pop),
    .arb               (arb_if),
    .ib_line_valid     (ib_line_valid),
    .ib_line_data      (ib_line_data),
    .ib_line_pc        (ib_line_pc),
    .ib_line_start_idx (ib_line_start_idx),
    .ib_clear          (ib_clear),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // stimulus knobs (percentages) and arbiter response latency range
  int redir_pct, hold_pct, pop_pct, gnt_pct, rv_lo, rv_hi;
  bit          force_redir;
  logic [63:0] force_tgt;
  bit          rv_pend;
  int          rv_cnt;

  // model: fetch pc, first-line flag, free ibuffer entries, request phase
  logic [63:0]  m_pc;
  bit           m_first;
  int           m_cred;
  bit           m_req, m_wait, m_drop;
  bit           e_valid, e_clear;
  logic [511:0] e_data;
  logic [63:0]  e_pc;
  logic [3:0]   e_idx;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 64'h8000_0000; m_first = 1'b1; m_cred = 24;
    m_req = 1'b0; m_wait = 1'b0; m_drop = 1'b0;
    e_valid = 1'b0; e_clear = 1'b0; e_data = '0; e_pc = '0; e_idx = '0;
  endtask

  task automatic check_outputs();
    chk("req",        512'(arb_if.ifu2arb_req),  512'(m_req));
    chk("addr",       512'(arb_if.ifu2arb_addr), 512'(m_pc & ~64'h3F));
    chk("line_valid", 512'(ib_line_valid),       512'(e_valid));
    chk("clear",      512'(ib_clear),            512'(e_clear));
    chk("busy",       512'(busy),                512'(m_req | m_wait | m_drop));
    if (e_valid) begin
      chk("line_data", ib_line_data,             e_data);
      chk("line_pc",   512'(ib_line_pc),         512'(e_pc));
      chk("start_idx", 512'(ib_line_start_idx),  512'(e_idx));
    end
  endtask

  task automatic check_reset_values();
    check_outputs();
    chk("rst_data", ib_line_data,             512'(0));
    chk("rst_pc",   512'(ib_line_pc),         512'(0));
    chk("rst_idx",  512'(ib_line_start_idx),  512'(0));
  endtask

  function automatic logic [63:0] pick_target();
    case ($urandom_range(0, 2))
      0:       return {$urandom, $urandom};
      1:       return 64'hFFFF_FFFF_FFFF_FF00 | 64'($urandom_range(0, 255));
      default: return 64'h8000_0000 + 64'($urandom_range(0, 4095));
    endcase
  endfunction

  task automatic drive_idle();
    redirect_valid = 1'b0; redirect_target = '0; fetch_hold = 1'b0; ib_pop = 1'b0;
    arb_if.arb2ifu_gnt = 1'b0; arb_if.arb2ifu_rvalid = 1'b0; arb_if.arb2ifu_rdata = '0;
  endtask

  // Called at a falling edge: check, drive the next cycle's inputs, advance the model.
  task automatic step();
    logic rd, h, p, g, rv;
    logic [63:0]  tgt;
    logic [511:0] dat;
    logic [3:0]   idx;
    int nc;
    check_outputs();
    rd  = (redir_pct > 0) && ($urandom_range(0, 99) < redir_pct);
    tgt = pick_target();
    if (force_redir) begin rd = 1'b1; tgt = force_tgt; force_redir = 1'b0; end
    h  = ($urandom_range(0, 99) < hold_pct);
    p  = (m_cred < 24) && ($urandom_range(0, 99) < pop_pct);
    g  = m_req && ($urandom_range(0, 99) < gnt_pct);
    rv = rv_pend && (rv_cnt == 0);
    if (rv) rv_pend = 1'b0;
    else if (rv_pend) rv_cnt--;
    if (g) begin rv_pend = 1'b1; rv_cnt = $urandom_range(rv_lo, rv_hi); end
    for (int i = 0; i < 16; i++) dat[i*32 +: 32] = $urandom;

    redirect_valid = rd; redirect_target = tgt; fetch_hold = h; ib_pop = p;
    arb_if.arb2ifu_gnt = g; arb_if.arb2ifu_rvalid = rv; arb_if.arb2ifu_rdata = dat;

    e_valid = 1'b0;
    e_clear = rd;
    if (rd) begin
      // a granted-but-unanswered request leaves one response to swallow
      m_drop  = (m_req && g) || ((m_wait || m_drop) && !rv);
      m_req   = 1'b0; m_wait = 1'b0;
      m_pc    = tgt & ~64'h3;
      m_first = 1'b1;
      m_cred  = 24;
    end else begin
      nc = m_cred + int'(p);
      if (m_wait && rv) begin
        idx     = m_first ? m_pc[5:2] : 4'd0;
        e_valid = 1'b1; e_data = dat; e_pc = m_pc & ~64'h3F; e_idx = idx;
        nc      = nc - 16 + int'(idx);
        m_pc    = e_pc + 64'd64;
        m_first = 1'b0; m_wait = 1'b0;
      end else if (m_drop && rv) begin
        m_drop = 1'b0;
      end else if (m_req && g) begin
        m_req = 1'b0; m_wait = 1'b1;
      end else if (!m_req && !m_wait && !m_drop && m_cred >= 16 && !h) begin
        m_req = 1'b1;
      end
      m_cred = (nc > 24) ? 24 : nc;
    end
    @(negedge clk);
  endtask

  task automatic set_knobs(input int rd_p, input int hd_p, input int pp_p, input int gn_p,
                           input int lo, input int hi);
    redir_pct = rd_p; hold_pct = hd_p; pop_pct = pp_p; gnt_pct = gn_p; rv_lo = lo; rv_hi = hi;
  endtask

  initial begin
    rst_n = 1'b0;
    drive_idle();
    set_knobs(0, 0, 0, 100, 2, 2);
    force_redir = 1'b0; force_tgt = '0; rv_pend = 1'b0; rv_cnt = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;

    // first line from reset: 3-cycle response, no pops, credits drop to 8
    repeat (20) step();
    pop_pct = 100;
    repeat (30) step();

    // mid-line redirect target, then sequential fetch
    force_redir = 1'b1; force_tgt = 64'h8000_0124; pop_pct = 0;
    repeat (30) step();
    pop_pct = 100;
    repeat (30) step();

    // line at the top of the address space wraps to 0
    force_redir = 1'b1; force_tgt = 64'hFFFF_FFFF_FFFF_FFC0;
    repeat (40) step();

    // hold only blocks new requests
    hold_pct = 100;
    repeat (20) step();
    hold_pct = 0;
    repeat (10) step();

    set_knobs(6, 20, 50, 60, 0, 4);
    repeat (4000) step();

    // asynchronous reset while a line is in flight
    for (int i = 0; i < 300 && !m_wait; i++) step();
    chk("wait_reached", 512'(busy & m_wait), 512'(1));
    drive_idle();
    rv_pend = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (600) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
